// File: rtl/etroc2_frame_receiver.sv
// ETROC2 receive path: self-synchronous descrambler (x^58+x^39+1), 8/16/32-to-40 gearbox
// and a sync-pattern bit-slip aligner that delivers 40-bit frames with a valid strobe.
//
// state     | meaning
// ST_HUNT   | searching; every non-matching frame slips the gearbox by one bit
// ST_VERIFY | pattern seen, counting consecutive matches up to LOCK_COUNT
// ST_LOCKED | aligned; counts frames since the last match, drops lock at MISS_LIMIT
module etroc2_frame_receiver #(
  parameter logic [15:0] SYNC_PATTERN = 16'h3C5C,
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned MISS_LIMIT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dataRate,
  input  logic [31:0] din,
  output logic [39:0] frame,
  output logic        frameValid,
  output logic        locked,
  output logic [5:0]  slipCount,
  output logic [7:0]  lockLossCnt
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_CNT_L = 8'(LOCK_COUNT);
  localparam logic [7:0] MISS_LIM_L = 8'(MISS_LIMIT);

  logic [1:0]  rate_q;
  logic        rate_chg;
  logic [6:0]  w_in;

  logic [57:0] hist_q, hist_d;
  logic [31:0] desc_q, desc_d;
  logic [6:0]  desc_w_q;

  logic [71:0] gb_q, gb_d, gb_ext, gb_sh;
  logic [6:0]  gb_cnt_q, gb_cnt_d, gb_total, gb_need;
  logic        slip_pend_q, slip_pend_d, slip_eff;
  logic [39:0] pre_frame_q, pre_frame_d;
  logic        pre_valid_q, pre_valid_d;

  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  miss_q, miss_d;
  logic [5:0]  slip_q, slip_d;
  logic [7:0]  loss_q, loss_d;
  logic        slip_req;
  logic        match;

  logic [39:0] frame_q, frame_d;
  logic        frame_valid_q;

  assign rate_chg = (dataRate != rate_q);

  always_comb begin
    case (dataRate)
      2'b00:   w_in = 7'd8;
      2'b01:   w_in = 7'd16;
      default: w_in = 7'd32;
    endcase
  end

  // The word that carries a rate change is decoded against a cleared history.
  always_comb begin
    hist_d = rate_chg ? '0 : hist_q;
    desc_d = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(w_in)) begin
        desc_d[i] = din[i] ^ hist_d[38] ^ hist_d[57];
        hist_d    = {hist_d[56:0], din[i]};
      end
    end
  end

  // Buffer is right-aligned: the oldest valid bit sits at gb_total-1.
  always_comb begin
    gb_ext      = (gb_q << desc_w_q) | {40'b0, desc_q};
    gb_total    = gb_cnt_q + desc_w_q;
    slip_eff    = slip_pend_q | slip_req;
    gb_need     = slip_eff ? 7'd41 : 7'd40;
    gb_d        = gb_ext;
    gb_cnt_d    = gb_total;
    gb_sh       = gb_ext;
    pre_frame_d = pre_frame_q;
    pre_valid_d = 1'b0;
    slip_pend_d = slip_eff;
    if (rate_chg) begin
      gb_d        = '0;
      gb_cnt_d    = '0;
      slip_pend_d = 1'b0;
    end else if (gb_total >= gb_need) begin
      gb_cnt_d    = gb_total - gb_need;
      gb_sh       = gb_ext >> gb_cnt_d;
      pre_frame_d = gb_sh[39:0];
      pre_valid_d = 1'b1;
      slip_pend_d = 1'b0;
    end
  end

  assign match = (pre_frame_q[39:38] == 2'b00) && (pre_frame_q[37:22] == SYNC_PATTERN);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    miss_d   = miss_q;
    slip_d   = slip_q;
    loss_d   = loss_q;
    slip_req = 1'b0;
    if (rate_chg) begin
      state_d = ST_HUNT;
      good_d  = '0;
      miss_d  = '0;
      if (state_q == ST_LOCKED && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end else if (pre_valid_q) begin
      case (state_q)
        ST_HUNT: begin
          if (match) begin
            if (LOCK_COUNT == 1) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              state_d = ST_VERIFY;
              good_d  = 8'd1;
            end
          end else begin
            slip_req = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (match) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 == LOCK_CNT_L) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            state_d  = ST_HUNT;
            good_d   = '0;
            slip_req = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            miss_d = '0;
          end else if (miss_q + 8'd1 == MISS_LIM_L) begin
            state_d = ST_HUNT;
            miss_d  = '0;
            good_d  = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end else begin
            miss_d = miss_q + 8'd1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (slip_req) slip_d = (slip_q == 6'd39) ? 6'd0 : slip_q + 6'd1;
  end

  assign frame_d = (pre_valid_q && !rate_chg) ? pre_frame_q : frame_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q        <= 2'b00;
      hist_q        <= '0;
      desc_q        <= '0;
      desc_w_q      <= '0;
      gb_q          <= '0;
      gb_cnt_q      <= '0;
      slip_pend_q   <= 1'b0;
      pre_frame_q   <= '0;
      pre_valid_q   <= 1'b0;
      state_q       <= ST_HUNT;
      good_q        <= '0;
      miss_q        <= '0;
      slip_q        <= '0;
      loss_q        <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      rate_q        <= dataRate;
      hist_q        <= hist_d;
      desc_q        <= desc_d;
      desc_w_q      <= w_in;
      gb_q          <= gb_d;
      gb_cnt_q      <= gb_cnt_d;
      slip_pend_q   <= slip_pend_d;
      pre_frame_q   <= pre_frame_d;
      pre_valid_q   <= pre_valid_d;
      state_q       <= state_d;
      good_q        <= good_d;
      miss_q        <= miss_d;
      slip_q        <= slip_d;
      loss_q        <= loss_d;
      frame_q       <= frame_d;
      frame_valid_q <= pre_valid_q & ~rate_chg;
    end
  end

  assign frame       = frame_q;
  assign frameValid  = frame_valid_q;
  assign locked      = (state_q == ST_LOCKED);
  assign slipCount   = slip_q;
  assign lockLossCnt = loss_q;

endmodule

// File: tb/tb_etroc2_frame_receiver.sv
// Bench for etroc2_frame_receiver: scrambled generator stream in, bit-queue reference model,
// outputs compared every cycle three clocks after the word that produced them.
module tb_etroc2_frame_receiver;
  localparam int LOCK_COUNT = 8;
  localparam int MISS_LIMIT = 64;
  localparam logic [15:0] SYNC = 16'h3C5C;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
  localparam int G_FILL = 0, G_MIXED = 1, G_DATA = 2, G_CORRUPT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  dataRate = 2'b10;
  logic [31:0] din = '0;
  logic [39:0] frame;
  logic        frameValid, locked;
  logic [5:0]  slipCount;
  logic [7:0]  lockLossCnt;

  etroc2_frame_receiver #(.SYNC_PATTERN(SYNC), .LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT)) dut (
    .clk(clk), .reset(reset), .dataRate(dataRate), .din(din),
    .frame(frame), .frameValid(frameValid), .locked(locked),
    .slipCount(slipCount), .lockLossCnt(lockLossCnt)
  );

  always #12 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [39:0] frm;
    int          st, good, miss, slip, loss;
    bit          pend;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  bit   tx_q[$];
  bit   scr_q[$];
  bit   rx_s[$];
  bit   rx_d[$];
  exp_t exp_q[$];
  exp_t committed;
  int   gen_mode = G_FILL;
  int   frame_no = 0;
  int   m_st, m_good, m_miss, m_slip, m_loss;
  bit   m_pend;
  logic [1:0] prev_rate;

  function automatic int width_of(logic [1:0] r);
    return (r == 2'b00) ? 8 : (r == 2'b01) ? 16 : 32;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_frame();
    logic [39:0] f, data, fill;
    data = {2'b10, 6'($urandom), 32'($urandom)};
    fill = {2'b00, SYNC, 22'($urandom)};
    case (gen_mode)
      G_FILL:  f = fill;
      G_MIXED: f = (frame_no % 5 == 0) ? fill : data;
      G_DATA:  f = data;
      default: f = (frame_no % 8 == 7) ? (fill ^ 40'h00_0100_0000) : fill;
    endcase
    frame_no++;
    for (int b = 39; b >= 0; b--) tx_q.push_back(f[b]);
  endtask

  function automatic bit scr_tap(int k);
    return (scr_q.size() >= k) ? scr_q[scr_q.size() - k] : 1'b0;
  endfunction

  task automatic gen_word(input int w, output logic [31:0] word);
    bit d, s;
    word = $urandom;
    while (tx_q.size() < w) gen_frame();
    for (int i = w - 1; i >= 0; i--) begin
      d = tx_q.pop_front();
      s = d ^ scr_tap(39) ^ scr_tap(58);
      scr_q.push_back(s);
      if (scr_q.size() > 58) void'(scr_q.pop_front());
      word[i] = s;
    end
  endtask

  task automatic gen_reset(input int offset);
    tx_q.delete();
    scr_q.delete();
    frame_no = 0;
    for (int i = 0; i < offset; i++) tx_q.push_back(1'($urandom_range(0, 1)));
  endtask

  function automatic exp_t snapshot(bit v, logic [39:0] f);
    exp_t e;
    e.valid = v; e.frm = f; e.st = m_st; e.good = m_good; e.miss = m_miss;
    e.slip = m_slip; e.loss = m_loss; e.pend = m_pend;
    return e;
  endfunction

  task automatic judge(input logic [39:0] f);
    bit match;
    bit slip;
    match = (f[39:38] == 2'b00) && (f[37:22] == SYNC);
    slip  = 1'b0;
    if (m_st == M_HUNT) begin
      if (match) begin
        if (LOCK_COUNT == 1) begin m_st = M_LOCKED; m_miss = 0; end
        else begin m_st = M_VERIFY; m_good = 1; end
      end else slip = 1'b1;
    end else if (m_st == M_VERIFY) begin
      if (match) begin
        m_good++;
        if (m_good == LOCK_COUNT) begin m_st = M_LOCKED; m_miss = 0; end
      end else begin
        m_st = M_HUNT; m_good = 0; slip = 1'b1;
      end
    end else begin
      if (match) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == MISS_LIMIT) begin
          m_st = M_HUNT; m_miss = 0; m_good = 0;
          if (m_loss < 255) m_loss++;
        end
      end
    end
    if (slip) begin
      m_slip = (m_slip + 1) % 40;
      m_pend = 1'b1;
    end
  endtask

  task automatic model_word(input logic [1:0] rate, input logic [31:0] word);
    int w, n;
    bit s, d;
    logic [39:0] f;
    w = width_of(rate);
    if (rate != prev_rate) begin
      // frames still in flight are lost; state falls back to the last one already delivered
      m_st = committed.st; m_slip = committed.slip; m_loss = committed.loss;
      if (m_st == M_LOCKED && m_loss < 255) m_loss++;
      m_st = M_HUNT; m_good = 0; m_miss = 0; m_pend = 1'b0;
      rx_s.delete();
      rx_d.delete();
      foreach (exp_q[k]) exp_q[k] = snapshot(1'b0, '0);
    end
    prev_rate = rate;
    for (int i = w - 1; i >= 0; i--) begin
      s = word[i];
      n = rx_s.size();
      d = s ^ ((n >= 39) ? rx_s[n - 39] : 1'b0) ^ ((n >= 58) ? rx_s[n - 58] : 1'b0);
      rx_s.push_back(s);
      if (rx_s.size() > 58) void'(rx_s.pop_front());
      rx_d.push_back(d);
    end
    if (rx_d.size() >= 40 + int'(m_pend)) begin
      if (m_pend) void'(rx_d.pop_front());
      m_pend = 1'b0;
      for (int b = 39; b >= 0; b--) f[b] = rx_d.pop_front();
      judge(f);
      exp_q.push_back(snapshot(1'b1, f));
    end else begin
      exp_q.push_back(snapshot(1'b0, '0));
    end
  endtask

  task automatic model_reset();
    m_st = M_HUNT; m_good = 0; m_miss = 0; m_slip = 0; m_loss = 0; m_pend = 1'b0;
    rx_s.delete();
    rx_d.delete();
    exp_q.delete();
    committed = snapshot(1'b0, '0);
    prev_rate = 2'b00;
  endtask

  task automatic step(input logic [1:0] rate);
    exp_t e;
    logic [31:0] word;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      committed = e;
      chk("frameValid", 64'(frameValid), 64'(e.valid));
      chk("locked", 64'(locked), 64'(e.st == M_LOCKED));
      chk("slipCount", 64'(slipCount), 64'(e.slip));
      chk("lockLossCnt", 64'(lockLossCnt), 64'(e.loss));
      if (e.valid) chk("frame", 64'(frame), 64'(e.frm));
    end
    gen_word(width_of(rate), word);
    dataRate = rate;
    din = word;
    model_word(rate, word);
    @(negedge clk);
  endtask

  task automatic run(input logic [1:0] rate, input int n);
    for (int i = 0; i < n; i++) step(rate);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_frame", 64'(frame), 64'd0);
    chk("rst_frameValid", 64'(frameValid), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_slipCount", 64'(slipCount), 64'd0);
    chk("rst_lockLossCnt", 64'(lockLossCnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    do_reset();

    gen_mode = G_FILL;
    gen_reset(13);
    run(2'b10, 300);
    chk("lock_32bit", 64'(locked), 64'd1);
    chk("loss_after_lock", 64'(lockLossCnt), 64'd0);

    gen_mode = G_MIXED;
    run(2'b10, 200);
    chk("lock_mixed", 64'(locked), 64'd1);

    gen_mode = G_FILL;
    gen_reset(7);
    run(2'b01, 1);
    chk("ratechg_unlock", 64'(locked), 64'd0);
    chk("ratechg_loss", 64'(lockLossCnt), 64'd1);
    run(2'b01, 400);
    chk("lock_16bit", 64'(locked), 64'd1);

    gen_reset(29);
    run(2'b00, 700);
    chk("lock_8bit", 64'(locked), 64'd1);
    chk("loss_8bit", 64'(lockLossCnt), 64'd2);

    gen_mode = G_DATA;
    run(2'b00, 5 * MISS_LIMIT + 40);
    chk("miss_unlock", 64'(locked), 64'd0);
    chk("miss_loss", 64'(lockLossCnt), 64'd3);

    gen_mode = G_CORRUPT;
    gen_reset(5);
    run(2'b10, 400);
    chk("corrupt_no_lock", 64'(locked), 64'd0);
    chk("corrupt_loss", 64'(lockLossCnt), 64'd3);

    gen_mode = G_FILL;
    run(2'b10, 300);
    chk("relock", 64'(locked), 64'd1);

    do_reset();
    gen_reset(0);
    run(2'b10, 100);
    chk("lock_after_reset", 64'(locked), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
